// File: rtl/usb_pkg.sv
// Shared USB constants and the IN-transaction sequencer state type.
package usb_pkg;

    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        SEND_IN,
        WAIT_RESP,
        SEND_ACK,
        DONE
    } state_t;

endpackage

// File: rtl/usb_in_txn_ctrl_if.sv
// Bundle between the IN sequencer, the read/write layer and the packet sender/receiver.
interface usb_in_txn_ctrl_if;

    logic        read_req;
    logic [6:0]  read_addr;
    logic [3:0]  read_endp;
    logic        busy;
    logic        read_done;
    logic        read_success;
    logic [63:0] read_data;
    logic        tx_start;
    logic [3:0]  tx_pid;
    logic [6:0]  tx_addr;
    logic [3:0]  tx_endp;
    logic        tx_done;
    logic        host_sending;
    logic        rec_ACK;
    logic        rec_NAK;
    logic        rec_DATA0;
    logic        data_valid;
    logic [63:0] data_rec;

    // master is the sequencer; slave is everything around it
    modport master (
        input  read_req, read_addr, read_endp, tx_done,
               rec_ACK, rec_NAK, rec_DATA0, data_valid, data_rec,
        output busy, read_done, read_success, read_data,
               tx_start, tx_pid, tx_addr, tx_endp, host_sending
    );

    modport slave (
        output read_req, read_addr, read_endp, tx_done,
               rec_ACK, rec_NAK, rec_DATA0, data_valid, data_rec,
        input  busy, read_done, read_success, read_data,
               tx_start, tx_pid, tx_addr, tx_endp, host_sending
    );

endinterface

// File: rtl/usb_resp_timer.sv
// Response-wait timer: counts while enabled and flags the last allowed cycle.
module usb_resp_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign o_expired = (r_count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/usb_in_txn_ctrl.sv
// Host-side USB IN transaction sequencer: IN token, wait for DATA0/NAK/timeout,
// ACK good data, retry failures up to MAX_ATTEMPTS.
module usb_in_txn_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_ATTEMPTS   = 8
) (
    input  logic              clock,
    input  logic              reset,
    usb_in_txn_ctrl_if.master bus
);

    import usb_pkg::*;

    localparam int             AW    = $clog2(MAX_ATTEMPTS + 1);
    localparam logic [AW-1:0]  MAX_A = AW'(MAX_ATTEMPTS);

    state_t        r_state;
    state_t        w_next;
    logic          r_firstCycle;
    logic [3:0]    r_txPid;
    logic [6:0]    r_txAddr;
    logic [3:0]    r_txEndp;
    logic [63:0]   r_readData;
    logic [AW-1:0] r_attempts;
    logic          r_success;

    logic w_latchReq;
    logic w_retry;
    logic w_latchData;
    logic w_setSuccess;
    logic w_timerClr;
    logic w_timerEn;
    logic w_expired;

    usb_resp_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_timerClr),
        .i_enable  (w_timerEn),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next       = r_state;
        w_latchReq   = 1'b0;
        w_retry      = 1'b0;
        w_latchData  = 1'b0;
        w_setSuccess = 1'b0;
        w_timerClr   = 1'b0;
        w_timerEn    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.read_req) begin
                    w_latchReq = 1'b1;
                    w_next     = SEND_IN;
                end
            end
            SEND_IN: begin
                if (bus.tx_done) begin
                    w_timerClr = 1'b1;
                    w_next     = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                w_timerEn = 1'b1;
                // A real response in the expiry cycle beats the timeout
                if (bus.rec_DATA0 && bus.data_valid) begin
                    w_latchData = 1'b1;
                    w_next      = SEND_ACK;
                end else if (bus.rec_DATA0 || bus.rec_NAK || bus.rec_ACK || w_expired) begin
                    if (r_attempts < MAX_A) begin
                        w_retry = 1'b1;
                        w_next  = SEND_IN;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            SEND_ACK: begin
                if (bus.tx_done) begin
                    w_setSuccess = 1'b1;
                    w_next       = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_firstCycle <= 1'b0;
            r_txPid      <= '0;
            r_txAddr     <= '0;
            r_txEndp     <= '0;
            r_readData   <= '0;
            r_attempts   <= '0;
            r_success    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_firstCycle <= (w_next != r_state);
            if (w_latchReq) begin
                r_txAddr   <= bus.read_addr;
                r_txEndp   <= bus.read_endp;
                r_attempts <= AW'(1);
                r_success  <= 1'b0;
                r_txPid    <= PID_IN;
            end
            if (w_retry) begin
                r_attempts <= r_attempts + AW'(1);
                r_txPid    <= PID_IN;
            end
            if (w_latchData) begin
                r_readData <= bus.data_rec;
                r_txPid    <= PID_ACK;
            end
            if (w_setSuccess) begin
                r_success <= 1'b1;
            end
        end
    end

    assign bus.busy         = (r_state != IDLE);
    assign bus.read_done    = (r_state == DONE);
    assign bus.read_success = r_success;
    assign bus.read_data    = r_readData;
    assign bus.host_sending = (r_state == SEND_IN) || (r_state == SEND_ACK);
    assign bus.tx_start     = r_firstCycle && ((r_state == SEND_IN) || (r_state == SEND_ACK));
    assign bus.tx_pid       = r_txPid;
    assign bus.tx_addr      = r_txAddr;
    assign bus.tx_endp      = r_txEndp;

endmodule
